// File: rtl/cnt_tk1_scheduler.sv
// Romulus block counter (56-bit LFSR) and TK1 round-key sequencer for SKINNY-128-384+.
// Only the non-zero 64-bit half of TK1 is stored; cnt_expansion advances it two rounds at a time.

module cnt_expansion (
   input  logic [63:0] tk_in,
   output logic [63:0] tk_out
);
   // SKINNY tweakey cell permutation applied twice, restricted to cells 0..7
   localparam int unsigned PERM2 [8] = '{1, 7, 0, 5, 2, 6, 4, 3};

   for (genvar gi = 0; gi < 8; gi++) begin : g_cell
      assign tk_out[63-8*gi -: 8] = tk_in[63-8*PERM2[gi] -: 8];
   end
endmodule

module cnt_tk1_scheduler #(
   parameter int ROUNDS = 40,
   parameter int RW     = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cnt_init,
   input  logic          cnt_inc,
   input  logic [7:0]    dom,
   input  logic          start,
   input  logic          rk_hold,
   output logic          busy,
   output logic          rk_valid,
   output logic [RW-1:0] rk_round,
   output logic [63:0]   rk_tk1,
   output logic          done,
   output logic [55:0]   cnt
);
   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

   state_t        state_q, state_d;
   logic [55:0]   cnt_q, cnt_d;
   logic [63:0]   tk_q, tk_d;
   logic [RW-1:0] round_q, round_d;
   logic          done_q, done_d;

   logic [63:0]   tk_perm;
   logic [63:0]   start_word;
   logic [55:0]   cnt_step;

   // x^56 + x^7 + x^4 + x^2 + 1, Galois form
   assign cnt_step = {cnt_q[54:0], 1'b0} ^ (cnt_q[55] ? 56'h95 : 56'h0);

   // Counter enters TK1 least-significant byte first, domain byte last
   for (genvar gi = 0; gi < 7; gi++) begin : g_load
      assign start_word[63-8*gi -: 8] = cnt_q[8*gi +: 8];
   end
   assign start_word[7:0] = dom;

   cnt_expansion u_expansion (
      .tk_in  (tk_q),
      .tk_out (tk_perm)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tk_d    = tk_q;
      round_d = round_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cnt_init) begin
               cnt_d = 56'h1;
            end else if (cnt_inc) begin
               cnt_d = cnt_step;
            end
            if (start) begin
               tk_d    = start_word;
               round_d = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!rk_hold) begin
               // After an odd round the live bytes return to rows 0-1
               if (round_q[0]) begin
                  tk_d = tk_perm;
               end
               if (round_q == LAST_ROUND) begin
                  round_d = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  round_d = round_q + RW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 56'h1;
         tk_q    <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tk_q    <= tk_d;
         round_q <= round_d;
         done_q  <= done_d;
      end
   end

   assign busy     = (state_q == S_RUN);
   assign rk_valid = busy;
   assign rk_round = round_q;
   assign rk_tk1   = (busy && !round_q[0]) ? tk_q : 64'h0;
   assign done     = done_q;
   assign cnt      = cnt_q;
endmodule

// File: tb/tb_cnt_tk1_scheduler.sv
// Randomized self-checking bench for cnt_tk1_scheduler against a full 16-cell TK1 model.

module tb_cnt_tk1_scheduler;
   localparam int ROUNDS = 40;
   localparam int RW     = 6;
   localparam int PT [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cnt_init = 1'b0;
   logic          cnt_inc = 1'b0;
   logic [7:0]    dom = 8'h0;
   logic          start = 1'b0;
   logic          rk_hold = 1'b0;
   logic          busy;
   logic          rk_valid;
   logic [RW-1:0] rk_round;
   logic [63:0]   rk_tk1;
   logic          done;
   logic [55:0]   cnt;

   int          checks = 0;
   int          errors = 0;
   logic [55:0] cnt_m = 56'h1;

   cnt_tk1_scheduler #(.ROUNDS(ROUNDS), .RW(RW)) dut (
      .clk      (clk),
      .rst      (rst),
      .cnt_init (cnt_init),
      .cnt_inc  (cnt_inc),
      .dom      (dom),
      .start    (start),
      .rk_hold  (rk_hold),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_round (rk_round),
      .rk_tk1   (rk_tk1),
      .done     (done),
      .cnt      (cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [55:0] lfsr(input logic [55:0] c);
      return {c[54:0], 1'b0} ^ (c[55] ? 56'h95 : 56'h0);
   endfunction

   // Full 128-bit TK1 (bottom half starts zero), permuted r times; rk is rows 0-1
   function automatic logic [63:0] tk_model(input logic [63:0] b, input int r);
      logic [7:0]  c [16];
      logic [7:0]  n [16];
      logic [63:0] res;
      for (int i = 0; i < 8; i++) begin
         c[i]   = b[63-8*i -: 8];
         c[i+8] = 8'h0;
      end
      for (int k = 0; k < r; k++) begin
         for (int i = 0; i < 16; i++) n[i] = c[PT[i]];
         c = n;
      end
      res = '0;
      for (int i = 0; i < 8; i++) res[63-8*i -: 8] = c[i];
      return res;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic incs(input int n);
      for (int i = 0; i < n; i++) begin
         cnt_inc = 1'b1;
         cnt_m   = lfsr(cnt_m);
         @(negedge clk);
      end
      cnt_inc = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      cnt_m = 56'h1;
      @(negedge clk);
   endtask

   task automatic run_seq(input logic [7:0] d, input bit inc_f, input bit init_f,
                          input int hold_at, input int hold_len, input int pct,
                          input int abort_at, input int mode);
      logic [63:0] base;
      int r, holds, hc, cyc;
      bit fin, h;
      base = {cnt_m[7:0], cnt_m[15:8], cnt_m[23:16], cnt_m[31:24],
              cnt_m[39:32], cnt_m[47:40], cnt_m[55:48], d};
      if (init_f) cnt_m = 56'h1;
      else if (inc_f) cnt_m = lfsr(cnt_m);
      dom = d; start = 1'b1; cnt_inc = inc_f; cnt_init = init_f;
      @(negedge clk);
      start = 1'b0; cnt_inc = 1'b0; cnt_init = 1'b0;
      r = 0; holds = 0; hc = 0; cyc = 0; fin = 1'b0;
      while (!fin && cyc <= 1000) begin
         if (r == ROUNDS) begin
            rk_hold = 1'b0; start = 1'b0; cnt_inc = 1'b0; cnt_init = 1'b0;
            chk("done_pulse", done, 1'b1);
            chk("done_busy", busy, 1'b0);
            chk("done_valid", rk_valid, 1'b0);
            chk("done_tk", rk_tk1, 64'h0);
            chk("done_latency", cyc, ROUNDS + holds);
            chk("done_cnt", cnt, cnt_m);
            @(negedge clk);
            chk("done_single", done, 1'b0);
            fin = 1'b1;
         end else if (r == abort_at) begin
            rk_hold = 1'b0; start = 1'b0; cnt_inc = 1'b0; cnt_init = 1'b0;
            rst = 1'b1;
            #1;
            chk("abort_busy", busy, 1'b0);
            chk("abort_valid", rk_valid, 1'b0);
            chk("abort_tk", rk_tk1, 64'h0);
            chk("abort_round", rk_round, '0);
            chk("abort_cnt", cnt, 56'h1);
            rst = 1'b0;
            cnt_m = 56'h1;
            repeat (3) begin
               @(negedge clk);
               chk("abort_no_done", done, 1'b0);
               chk("abort_idle", busy, 1'b0);
            end
            fin = 1'b1;
         end else begin
            chk("run_busy", busy, 1'b1);
            chk("run_valid", rk_valid, 1'b1);
            chk("run_done", done, 1'b0);
            chk("run_round", rk_round, r[RW-1:0]);
            chk("run_tk", rk_tk1, tk_model(base, r));
            chk("run_cnt_frozen", cnt, cnt_m);
            if (mode == 1) begin
               if (r == 0) chk("tk_r0", rk_tk1, 64'h0100_0000_0000_0000);
               if (r == 1) chk("tk_r1", rk_tk1, 64'h0);
               if (r == 2) chk("tk_r2", rk_tk1, 64'h0000_0100_0000_0000);
               if (r == 4) chk("tk_r4", rk_tk1, 64'h0000_0000_0100_0000);
            end else if (mode == 2 && r == 0) begin
               chk("tk_r0_dom4a", rk_tk1, 64'h0100_0000_0000_004A);
            end
            h = 1'b0;
            if (r == hold_at && hc < hold_len) begin
               h = 1'b1;
               hc++;
            end else if (pct > 0 && $urandom_range(99) < pct) begin
               h = 1'b1;
            end
            rk_hold  = h;
            cnt_inc  = 1'($urandom_range(1));
            cnt_init = 1'($urandom_range(1));
            start    = 1'($urandom_range(1));
            dom      = 8'($urandom);
            if (h) holds++;
            else r++;
            @(negedge clk);
            cyc++;
         end
      end
      rk_hold = 1'b0; start = 1'b0; cnt_inc = 1'b0; cnt_init = 1'b0;
      checks++;
      assert (fin) else begin
         errors++;
         $error("FAIL run_timeout observed=no_done expected=done");
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", rk_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_tk", rk_tk1, 64'h0);
      chk("rst_round", rk_round, '0);
      chk("rst_cnt", cnt, 56'h1);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_cnt", cnt, 56'h1);

      incs(1);
      chk("inc1", cnt, 56'h2);
      pulse_rst();
      incs(55);
      chk("inc55", cnt, 56'h80_0000_0000_0000);
      chk("inc55_model", cnt, cnt_m);
      incs(1);
      chk("inc56", cnt, 56'h95);

      pulse_rst();
      run_seq(8'h00, 1'b0, 1'b0, -1, 0, 0, -1, 1);
      run_seq(8'h00, 1'b0, 1'b0, 5, 3, 0, -1, 1);

      incs(4);
      chk("inc4", cnt, cnt_m);
      cnt_init = 1'b1; cnt_inc = 1'b1; cnt_m = 56'h1;
      @(negedge clk);
      cnt_init = 1'b0; cnt_inc = 1'b0;
      chk("init_prio", cnt, 56'h1);

      run_seq(8'h4A, 1'b1, 1'b0, -1, 0, 0, -1, 2);
      chk("start_inc_cnt", cnt, 56'h2);

      run_seq(8'h33, 1'b0, 1'b0, -1, 0, 0, 10, 0);
      run_seq(8'h00, 1'b0, 1'b0, -1, 0, 0, -1, 1);

      for (int t = 0; t < 6; t++) begin
         incs(int'($urandom_range(20)));
         chk("rand_idle_cnt", cnt, cnt_m);
         run_seq(8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(3) == 0),
                 int'($urandom_range(ROUNDS - 1)), int'($urandom_range(4)), 25, -1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cnt_tk1_scheduler.md
Name: cnt_tk1_scheduler

Overview:
- Owns the Romulus 56-bit block counter (LFSR) and the TK1 counter/domain tweakey state.
- Sequences per-round TK1 round-key contributions for a SKINNY-128-384+ encryption.
- Instantiates cnt_expansion once: the two-round TK1 permutation applied to the 64-bit non-zero half.
- Sits between the Romulus mode controller (init/inc/start) and the round datapath (rk_valid/rk_hold).

Parameters:
- ROUNDS, 40, number of SKINNY rounds per call; must be even and ≥2.
- RW, 6, width of round index output; must satisfy 2^RW ≥ ROUNDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cnt_init  in  1  load counter with 56'h1 (IDLE only).
- cnt_inc  in  1  advance counter one LFSR step (IDLE only).
- dom  in  8  domain byte, sampled on start.
- start  in  1  begin round-key sequence (IDLE only).
- rk_hold  in  1  datapath stall; freezes the sequence while RUN.
- busy  out  1  high in RUN.
- rk_valid  out  1  round-key word valid this cycle.
- rk_round  out  RW  current round index.
- rk_tk1  out  64  TK1 round-key contribution (rows 0–1).
- done  out  1  one-cycle pulse after last round.
- cnt  out  56  current counter value.

Behaviour:
- Reset values: state=IDLE, cnt=56'h1, tk_state=0, round=0, busy=0, rk_valid=0, done=0, rk_tk1=0, rk_round=0.
- LFSR step (x^56+x^7+x^4+x^2+1): next = {cnt[54:0],1'b0} ^ (cnt[55] ? 56'h95 : 0). Never reaches 0; period 2^56−1.
- IDLE:
  - cnt_init has priority over cnt_inc.
  - start loads tk_state = {cnt[7:0],cnt[15:8],cnt[23:16],cnt[31:24],cnt[39:32],cnt[47:40],cnt[55:48],dom}, sets round=0, enters RUN.
  - Simultaneous start with init/inc: the counter update takes effect and tk_state loads the pre-update cnt.
- RUN:
  - busy=1, rk_valid=1 on every cycle, including held cycles.
  - rk_tk1 = tk_state when round is even; 64'h0 when odd (after one P the non-zero bytes sit in the unused half).
  - rk_round = round.
  - When rk_hold=0, the round advances by 1. On odd rounds, tk_state <= cnt_expansion(tk_state).
  - When rk_hold=1, all registers hold and outputs stay stable.
  - On advancing past round ROUNDS−1: state→IDLE, done=1 for exactly one cycle (busy=0, rk_valid=0 that cycle).
- Latency: start sampled at edge t; round 0 is valid in the cycle after t. With no holds, done is asserted ROUNDS cycles after round 0 first appears.
- In RUN, start, cnt_init and cnt_inc are ignored; cnt is frozen.
- rk_tk1 is 0 whenever not rk_valid.
- Async rst mid-RUN: all registers return immediately to reset values, including cnt=1. No done is emitted.

Test Plan:
- Reset, then 1 inc → cnt=56'h2. 55 incs from reset → cnt=56'h80_0000_0000_0000. 56 incs → cnt=56'h95.
- From reset, start with dom=8'h00 → rk_tk1 sequence:
  - round 0 = 64'h0100_0000_0000_0000, round 1 = 0;
  - round 2 = 64'h0000_0100_0000_0000;
  - round 4 = 64'h0000_0000_0100_0000;
  - done 40 cycles after round 0; rk_round counts 0..39.
- Hold rk_hold=1 for 3 cycles at round 5 → rk_round stays 5 and rk_tk1 stays constant; done is delayed by exactly 3 cycles.
- cnt_init and cnt_inc together in IDLE after 4 incs → cnt=1. cnt_inc during RUN → cnt unchanged.
- start with dom=8'h4A and simultaneous cnt_inc at cnt=1 → round 0 rk_tk1=64'h0100_0000_0000_004A; cnt=2 afterward.
- Assert rst at round 10 → busy=0, rk_valid=0, cnt=1 immediately; no done pulse. A new start works normally.
